sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares one SRAM-like bus between the IF-stage fetch port (inst) and the EX/MEM load/store port (data).
//  Arbitrates requests and holds the address phase until addr_ok.
//  Tracks outstanding transactions in order and routes each data_ok/rdata back to the requester that issued it.
//  Drops responses to fetches cancelled by an exception or ertn flush.
// PARAMETERS
//  MAX_OUTSTANDING  4  depth of in-order ID FIFO (power of 2, >=2); max accepted-but-unanswered transactions
// PORTS
//  clk            in   1   clock, all state on rising edge
//  resetn         in   1   asynchronous active-low reset
//  inst_req       in   1   fetch request; size/addr fixed word read
//  inst_addr      in   32  fetch address
//  inst_addr_ok   out  1   fetch request accepted this cycle
//  inst_data_ok   out  1   fetch data returned this cycle
//  inst_rdata     out  32  fetch data (= bus_rdata)
//  inst_cancel    in   1   discard all outstanding/in-flight fetch responses
//  data_req       in   1   load/store request
//  data_wr        in   1   1=store
//  data_size      in   2   0=byte 1=half 2=word
//  data_addr      in   32  access address
//  data_wstrb     in   4   byte enables (stores)
//  data_wdata     in   32  store data
//  data_addr_ok   out  1   data request accepted this cycle
//  data_data_ok   out  1   load data / store ack this cycle
//  data_rdata     out  32  load data (= bus_rdata)
//  bus_req        out  1   shared bus request
//  bus_wr         out  1   shared bus write
//  bus_size       out  2   shared bus size
//  bus_addr       out  32  shared bus address
//  bus_wstrb      out  4   shared bus strobes
//  bus_wdata      out  32  shared bus write data
//  bus_addr_ok    in   1   slave accepted address phase
//  bus_data_ok    in   1   slave returns response; strictly in acceptance order
//  bus_rdata      in   32  slave read data
//  err_spurious   out  1   sticky: bus_data_ok seen with ID FIFO empty
// BEHAVIOUR
//  Reset:
//   - State = IDLE; FIFO empty; all outputs 0; err_spurious = 0.
//  FSM:
//   - IDLE: if FIFO not full, grant data_req, else inst_req (data has fixed priority).
//   - Granted fields are driven combinationally onto bus_* and captured into a hold register.
//   - Winner with bus_addr_ok=1 -> push ID, stay IDLE.
//   - Winner with bus_addr_ok=0 -> HOLD_DATA / HOLD_INST.
//   - HOLD_x: bus_* driven from hold register; bus_req=1; no re-arbitration.
//   - HOLD_x on bus_addr_ok -> push ID, return to IDLE. Next grant is the earliest the cycle after.
//   - FIFO full: bus_req=0 in IDLE. A HOLD_x state is only entered with a free slot reserved.
//  Handshakes:
//   - x_addr_ok = bus_addr_ok & granted==x & bus_req. The loser sees addr_ok=0 and keeps its req.
//  ID FIFO entry {id, discard}:
//   - Push on bus_req & bus_addr_ok; pop on bus_data_ok.
//   - Push and pop in the same cycle are both performed (count unchanged).
//   - Pointers wrap modulo MAX_OUTSTANDING.
//  Response routing:
//   - On bus_data_ok, head id selects inst_data_ok or data_data_ok (1-cycle pulse, same cycle, no latency).
//   - A head entry with discard=1 pops with neither data_ok asserted.
//   - x_rdata = bus_rdata unconditionally.
//  inst_cancel (1 cycle):
//   - Sets discard on every valid inst entry, including one pushed that same cycle.
//   - An inst request in HOLD_INST still completes its address phase and is pushed with discard=1; inst_addr_ok is suppressed.
//   - Data entries are never discarded.
//  Cancel coinciding with a pop:
//   - The popped entry is still discarded if it was inst, i.e. no inst_data_ok that cycle.
//  Spurious response:
//   - bus_data_ok with FIFO empty -> ignored, no pop, err_spurious set until reset.
//  Reset mid-transaction:
//   - Asynchronous clear of all state; outstanding slave responses after reset count as spurious.
// TESTING
//  1. Single load: data_req, addr=0x1000, addr_ok the same cycle, data_ok 2 cycles later with rdata=0xDEADBEEF
//     -> data_data_ok=1 with 0xDEADBEEF, inst_data_ok=0.
//  2. inst_req and data_req together, bus_addr_ok=1 -> data granted first, inst granted the next cycle.
//     Responses in order route data then inst.
//  3. Address stall: data_req, bus_addr_ok low 3 cycles; inst_req raised meanwhile
//     -> bus_addr stays data_addr, inst_addr_ok=0 until data accepted.
//  4. Fill MAX_OUTSTANDING=4 inst fetches with no data_ok -> bus_req=0 on the 5th.
//     One data_ok -> next fetch accepted the following cycle.
//  5. 2 fetches + 1 load outstanding, pulse inst_cancel, return 3 responses
//     -> only data_data_ok pulses once; FIFO empty afterwards.
//  6. bus_data_ok with nothing outstanding -> err_spurious=1 and stays set.
//     Assert resetn=0 mid-HOLD -> all outputs 0 immediately.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port (inst) and the load/store port (data).
// The data port has fixed priority; responses are routed in order through an ID FIFO.
module sram_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        err_spurious
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned N  = MAX_OUTSTANDING;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_DATA = 2'd1,
    HOLD_INST = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   valid_q, valid_d;
  logic [N-1:0]   is_data_q, is_data_d;
  logic [N-1:0]   discard_q, discard_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           hold_wr_q, hold_wr_d;
  logic [1:0]     hold_size_q, hold_size_d;
  logic [31:0]    hold_addr_q, hold_addr_d;
  logic [3:0]     hold_wstrb_q, hold_wstrb_d;
  logic [31:0]    hold_wdata_q, hold_wdata_d;
  logic           hold_cancel_q, hold_cancel_d;
  logic           err_q, err_d;

  logic        grant_data, grant_inst;
  logic        full, empty, push, pop, push_discard, head_discard;
  logic        live_wr;
  logic [1:0]  live_size;
  logic [31:0] live_addr, live_wdata;
  logic [3:0]  live_wstrb;

  assign full  = valid_q[wr_ptr_q];
  assign empty = ~valid_q[rd_ptr_q];

  // Grants are gated by resetn so bus outputs read 0 while reset is held.
  always_comb begin
    state_d    = state_q;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    case (state_q)
      IDLE: begin
        if (resetn && !full) begin
          if (data_req)      grant_data = 1'b1;
          else if (inst_req) grant_inst = 1'b1;
        end
      end
      HOLD_DATA: grant_data = resetn;
      HOLD_INST: grant_inst = resetn;
      default: ;
    endcase
    if (grant_data || grant_inst) begin
      if (bus_addr_ok)     state_d = IDLE;
      else if (grant_data) state_d = HOLD_DATA;
      else                 state_d = HOLD_INST;
    end
  end

  always_comb begin
    live_wr    = 1'b0;
    live_size  = '0;
    live_addr  = '0;
    live_wstrb = '0;
    live_wdata = '0;
    if (grant_data) begin
      live_wr    = data_wr;
      live_size  = data_size;
      live_addr  = data_addr;
      live_wstrb = data_wstrb;
      live_wdata = data_wdata;
    end else if (grant_inst) begin
      live_size  = 2'd2;
      live_addr  = inst_addr;
    end
  end

  always_comb begin
    bus_req   = grant_data | grant_inst;
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_addr  = '0;
    bus_wstrb = '0;
    bus_wdata = '0;
    if (bus_req) begin
      if (state_q == IDLE) begin
        bus_wr    = live_wr;
        bus_size  = live_size;
        bus_addr  = live_addr;
        bus_wstrb = live_wstrb;
        bus_wdata = live_wdata;
      end else begin
        bus_wr    = hold_wr_q;
        bus_size  = hold_size_q;
        bus_addr  = hold_addr_q;
        bus_wstrb = hold_wstrb_q;
        bus_wdata = hold_wdata_q;
      end
    end
  end

  always_comb begin
    hold_wr_d    = hold_wr_q;
    hold_size_d  = hold_size_q;
    hold_addr_d  = hold_addr_q;
    hold_wstrb_d = hold_wstrb_q;
    hold_wdata_d = hold_wdata_q;
    if (state_q == IDLE && bus_req && !bus_addr_ok) begin
      hold_wr_d    = live_wr;
      hold_size_d  = live_size;
      hold_addr_d  = live_addr;
      hold_wstrb_d = live_wstrb;
      hold_wdata_d = live_wdata;
    end
  end

  // A fetch cancelled while stalled still finishes its address phase, but is tagged discard.
  assign push          = bus_req & bus_addr_ok;
  assign push_discard  = grant_inst & (inst_cancel | hold_cancel_q);
  assign hold_cancel_d = grant_inst & ~bus_addr_ok & (inst_cancel | hold_cancel_q);

  assign data_addr_ok = bus_addr_ok & grant_data;
  assign inst_addr_ok = bus_addr_ok & grant_inst & ~((state_q == HOLD_INST) & push_discard);

  assign pop          = bus_data_ok & ~empty;
  assign head_discard = discard_q[rd_ptr_q] | (inst_cancel & ~is_data_q[rd_ptr_q]);
  assign inst_data_ok = pop & ~is_data_q[rd_ptr_q] & ~head_discard;
  assign data_data_ok = pop & is_data_q[rd_ptr_q];
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign err_d        = err_q | (bus_data_ok & empty);
  assign err_spurious = err_q;

  // The push slot is always free (grants need a free slot), so push after pop is safe.
  always_comb begin
    valid_d   = valid_q;
    is_data_d = is_data_q;
    discard_d = discard_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (inst_cancel) discard_d = discard_q | (valid_q & ~is_data_q);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q]   = 1'b1;
      is_data_d[wr_ptr_q] = grant_data;
      discard_d[wr_ptr_q] = push_discard;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      is_data_q     <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      hold_wr_q     <= 1'b0;
      hold_size_q   <= '0;
      hold_addr_q   <= '0;
      hold_wstrb_q  <= '0;
      hold_wdata_q  <= '0;
      hold_cancel_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      is_data_q     <= is_data_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      hold_wr_q     <= hold_wr_d;
      hold_size_q   <= hold_size_d;
      hold_addr_q   <= hold_addr_d;
      hold_wstrb_q  <= hold_wstrb_d;
      hold_wdata_q  <= hold_wdata_d;
      hold_cancel_q <= hold_cancel_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: arbitration, address stalls, FIFO full,
// cancel handling, spurious responses and asynchronous reset.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cancel, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic        bus_req, bus_wr, err_spurious;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .err_spurious(err_spurious)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; inst_req = 0; inst_cancel = 0; data_req = 0; data_wr = 0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; data_size = '0; data_wstrb = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;

    #2;
    check_eq("rst_bus_req", 32'(bus_req), 0);
    check_eq("rst_err", 32'(err_spurious), 0);
    check_eq("rst_oks", {28'b0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    next_cycle(); next_cycle();
    resetn = 1'b1;
    next_cycle();

    // 1. single load
    data_req = 1; data_size = 2; data_addr = 32'h1000; bus_addr_ok = 1;
    @(negedge clk);
    check_eq("t1_bus_addr", bus_addr, 32'h1000);
    check_eq("t1_data_addr_ok", 32'(data_addr_ok), 1);
    check_eq("t1_inst_addr_ok", 32'(inst_addr_ok), 0);
    next_cycle();
    data_req = 0; bus_addr_ok = 0;
    next_cycle();
    bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("t1_data_data_ok", 32'(data_data_ok), 1);
    check_eq("t1_data_rdata", data_rdata, 32'hDEADBEEF);
    check_eq("t1_inst_data_ok", 32'(inst_data_ok), 0);
    next_cycle();
    bus_data_ok = 0;

    // 2. simultaneous requests: data wins, inst next cycle
    data_req = 1; data_addr = 32'h2000; inst_req = 1; inst_addr = 32'h3000; bus_addr_ok = 1;
    @(negedge clk);
    check_eq("t2_bus_addr_d", bus_addr, 32'h2000);
    check_eq("t2_data_addr_ok", 32'(data_addr_ok), 1);
    check_eq("t2_inst_addr_ok0", 32'(inst_addr_ok), 0);
    next_cycle();
    data_req = 0;
    @(negedge clk);
    check_eq("t2_bus_addr_i", bus_addr, 32'h3000);
    check_eq("t2_bus_size_i", 32'(bus_size), 2);
    check_eq("t2_inst_addr_ok1", 32'(inst_addr_ok), 1);
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h11;
    @(negedge clk);
    check_eq("t2_resp1_data", 32'(data_data_ok), 1);
    check_eq("t2_resp1_inst", 32'(inst_data_ok), 0);
    next_cycle();
    bus_rdata = 32'h22;
    @(negedge clk);
    check_eq("t2_resp2_inst", 32'(inst_data_ok), 1);
    check_eq("t2_resp2_data", 32'(data_data_ok), 0);
    check_eq("t2_inst_rdata", inst_rdata, 32'h22);
    next_cycle();
    bus_data_ok = 0;

    // 3. address stall of a store; inst waits
    data_req = 1; data_wr = 1; data_addr = 32'h4000; data_wstrb = 4'hF; data_wdata = 32'hCAFE;
    @(negedge clk);
    check_eq("t3_bus_req", 32'(bus_req), 1);
    next_cycle();
    data_addr = 32'h9999; inst_req = 1; inst_addr = 32'h5000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t3_hold_addr", bus_addr, 32'h4000);
      check_eq("t3_hold_wr", 32'(bus_wr), 1);
      check_eq("t3_inst_wait", 32'(inst_addr_ok), 0);
      next_cycle();
    end
    bus_addr_ok = 1;
    @(negedge clk);
    check_eq("t3_accept_ok", 32'(data_addr_ok), 1);
    check_eq("t3_accept_addr", bus_addr, 32'h4000);
    check_eq("t3_accept_wdata", bus_wdata, 32'hCAFE);
    check_eq("t3_accept_wstrb", 32'(bus_wstrb), 32'hF);
    check_eq("t3_inst_still0", 32'(inst_addr_ok), 0);
    next_cycle();
    data_req = 0; data_wr = 0;
    @(negedge clk);
    check_eq("t3_inst_ok", 32'(inst_addr_ok), 1);
    check_eq("t3_inst_addr", bus_addr, 32'h5000);
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    @(negedge clk);
    check_eq("t3_store_ack", 32'(data_data_ok), 1);
    next_cycle();
    @(negedge clk);
    check_eq("t3_inst_resp", 32'(inst_data_ok), 1);
    next_cycle();
    bus_data_ok = 0;

    // 4. fill the FIFO with fetches
    inst_req = 1; inst_addr = 32'h6000; bus_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_fill_ok", 32'(inst_addr_ok), 1);
      next_cycle();
    end
    bus_data_ok = 1;
    @(negedge clk);
    check_eq("t4_full_req", 32'(bus_req), 0);
    check_eq("t4_full_ok", 32'(inst_addr_ok), 0);
    check_eq("t4_pop", 32'(inst_data_ok), 1);
    next_cycle();
    bus_data_ok = 0;
    @(negedge clk);
    check_eq("t4_refill_req", 32'(bus_req), 1);
    check_eq("t4_refill_ok", 32'(inst_addr_ok), 1);
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_drain", 32'(inst_data_ok), 1);
      next_cycle();
    end
    bus_data_ok = 0;

    // 5. cancel with 2 fetches + 1 load outstanding
    bus_addr_ok = 1; inst_req = 1;
    next_cycle(); next_cycle();
    inst_req = 0; data_req = 1; data_addr = 32'hA000;
    next_cycle();
    data_req = 0; bus_addr_ok = 0; inst_cancel = 1;
    next_cycle();
    inst_cancel = 0; bus_data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t5_drop_inst", 32'(inst_data_ok), 0);
      check_eq("t5_drop_data", 32'(data_data_ok), 0);
      next_cycle();
    end
    @(negedge clk);
    check_eq("t5_load_ok", 32'(data_data_ok), 1);
    check_eq("t5_load_inst", 32'(inst_data_ok), 0);
    next_cycle();
    bus_data_ok = 0;

    // cancel coinciding with the pop of an inst entry
    inst_req = 1; bus_addr_ok = 1;
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; inst_cancel = 1;
    @(negedge clk);
    check_eq("t5b_pop_cancel", 32'(inst_data_ok), 0);
    next_cycle();
    bus_data_ok = 0; inst_cancel = 0;

    // cancel while a fetch is stalled in HOLD_INST
    inst_req = 1; inst_addr = 32'h7000;
    next_cycle();
    inst_req = 0; inst_cancel = 1;
    @(negedge clk);
    check_eq("t5c_hold_req", 32'(bus_req), 1);
    check_eq("t5c_hold_addr", bus_addr, 32'h7000);
    next_cycle();
    inst_cancel = 0; bus_addr_ok = 1;
    @(negedge clk);
    check_eq("t5c_accept_req", 32'(bus_req), 1);
    check_eq("t5c_ok_supp", 32'(inst_addr_ok), 0);
    next_cycle();
    bus_addr_ok = 0; bus_data_ok = 1;
    @(negedge clk);
    check_eq("t5c_resp_drop", 32'(inst_data_ok), 0);
    next_cycle();

    // 6. spurious response with FIFO empty
    @(negedge clk);
    check_eq("t6_pre_err", 32'(err_spurious), 0);
    check_eq("t6_no_ok", 32'(data_data_ok | inst_data_ok), 0);
    next_cycle();
    bus_data_ok = 0;
    @(negedge clk);
    check_eq("t6_err_set", 32'(err_spurious), 1);
    next_cycle(); next_cycle();
    check_eq("t6_err_sticky", 32'(err_spurious), 1);

    // reset asserted while in HOLD_DATA
    data_req = 1; data_addr = 32'h8000;
    @(negedge clk);
    check_eq("t6_pre_hold", bus_addr, 32'h8000);
    next_cycle();
    bus_addr_ok = 1; resetn = 0;
    #1;
    check_eq("t6_rst_req", 32'(bus_req), 0);
    check_eq("t6_rst_addr", bus_addr, 0);
    check_eq("t6_rst_dok", 32'(data_addr_ok), 0);
    check_eq("t6_rst_err", 32'(err_spurious), 0);
    data_req = 0; bus_addr_ok = 0;
    next_cycle();
    resetn = 1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
